// File: rtl/bn_share_sched.sv
// bn_share_sched: round-robin sharing of one batch-norm/ReLU datapath among
// NO_REQ requesters. Each requester has its own coefficient set. A tag pipe
// that runs in step with the datapath sends every result back to the
// requester that issued the beat.

// One requester's per-channel a/b coefficient set.
module bn_share_coef_set #(
  parameter int NO_CH = 10,
  parameter int BW_A  = 12,
  parameter int BW_B  = 12,
  parameter int CW    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [CW-1:0]         ch,
  input  logic [BW_A-1:0]       a,
  input  logic [BW_B-1:0]       b,
  output logic [NO_CH*BW_A-1:0] set_a,
  output logic [NO_CH*BW_B-1:0] set_b
);

  // Write one channel; an out-of-range channel matches no slot and is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      set_a <= '0;
      set_b <= '0;
    end else if (we) begin
      for (int c = 0; c < NO_CH; c++) begin
        if (ch == CW'(c)) begin
          set_a[c*BW_A +: BW_A] <= a;
          set_b[c*BW_B +: BW_B] <= b;
        end
      end
    end
  end

endmodule

module bn_share_sched #(
  parameter int NO_REQ = 4,
  parameter int NO_CH  = 10,
  parameter int BW_IN  = 12,
  parameter int BW_OUT = 12,
  parameter int BW_A   = 12,
  parameter int BW_B   = 12,
  parameter int DP_LAT = 4,
  localparam int SW = (NO_REQ > 1) ? $clog2(NO_REQ) : 1,
  localparam int CW = (NO_CH > 1) ? $clog2(NO_CH) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NO_REQ-1:0]              req,
  input  logic [NO_REQ*NO_CH*BW_IN-1:0]  req_data,
  output logic [NO_REQ-1:0]              gnt,
  input  logic                           cfg_we,
  input  logic [SW-1:0]                  cfg_sel,
  input  logic [CW-1:0]                  cfg_ch,
  input  logic [BW_A-1:0]                cfg_a,
  input  logic [BW_B-1:0]                cfg_b,
  output logic                           dp_vld_in,
  output logic [NO_CH*BW_IN-1:0]         dp_data_in,
  output logic [NO_CH*BW_A-1:0]          dp_a,
  output logic [NO_CH*BW_B-1:0]          dp_b,
  input  logic                           dp_vld_out,
  input  logic [NO_CH*BW_OUT-1:0]        dp_data_out,
  output logic [NO_REQ-1:0]              rsp_vld,
  output logic [NO_CH*BW_OUT-1:0]        rsp_data,
  output logic                           err
);

  localparam int MW = $clog2(DP_LAT + 1);

  logic [NO_REQ-1:0][NO_CH*BW_IN-1:0] req_arr;
  logic [NO_REQ-1:0][NO_CH*BW_A-1:0]  coef_a;
  logic [NO_REQ-1:0][NO_CH*BW_B-1:0]  coef_b;
  logic [SW-1:0]                      ptr, ptr_nxt, gidx, idx;
  logic                               hit, take;
  int                                 j;
  logic [DP_LAT:0]                    vld_pipe;
  logic [DP_LAT:0][SW-1:0]            tag_pipe;
  logic                               tag_vld;
  logic [SW-1:0]                      tag_k;
  logic [MW-1:0]                      mask_cnt;

  assign req_arr = req_data;

  // Coefficient sets, one per requester.
  for (genvar k = 0; k < NO_REQ; k++) begin : g_coef
    bn_share_coef_set #(.NO_CH(NO_CH), .BW_A(BW_A), .BW_B(BW_B), .CW(CW)) u_set (
      .clk   (clk),
      .rst   (rst),
      .we    (cfg_we && (cfg_sel == SW'(k))),
      .ch    (cfg_ch),
      .a     (cfg_a),
      .b     (cfg_b),
      .set_a (coef_a[k]),
      .set_b (coef_b[k])
    );
  end

  // Find the first requesting index at or above the pointer, wrapping around.
  always_comb begin
    hit  = 1'b0;
    gidx = '0;
    j    = 0;
    idx  = '0;
    for (int i = 0; i < NO_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NO_REQ) j = j - NO_REQ;
      idx = SW'(j);
      if (!hit && req[idx]) begin
        hit  = 1'b1;
        gidx = idx;
      end
    end
  end

  // A config write steals the cycle; no grant is given during reset either.
  assign take    = hit && !cfg_we && !rst;
  assign ptr_nxt = (gidx == SW'(NO_REQ - 1)) ? '0 : gidx + SW'(1);

  // One-hot grant from the winning index.
  always_comb begin
    gnt = '0;
    if (take) gnt[gidx] = 1'b1;
  end

  // Pointer moves past the winner; it holds on idle or blocked cycles.
  always_ff @(posedge clk) begin
    if (rst)       ptr <= '0;
    else if (take) ptr <= ptr_nxt;
  end

  // Issue register: payload and coefficients of the winner, held when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_data_in <= '0;
      dp_a       <= '0;
      dp_b       <= '0;
    end else if (take) begin
      dp_data_in <= req_arr[gidx];
      dp_a       <= coef_a[gidx];
      dp_b       <= coef_b[gidx];
    end
  end

  // Tag pipe: stage 0 sits beside dp_vld_in, the last stage beside dp_vld_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[DP_LAT-1:0], take};
      tag_pipe <= {tag_pipe[DP_LAT-1:0], gidx};
    end
  end

  assign dp_vld_in = vld_pipe[0];
  assign tag_vld   = vld_pipe[DP_LAT];
  assign tag_k     = tag_pipe[DP_LAT];
  assign rsp_data  = dp_data_out;

  // Steer a result only when the datapath and the tag pipe agree.
  always_comb begin
    rsp_vld = '0;
    if (tag_vld && dp_vld_out) rsp_vld[tag_k] = 1'b1;
  end

  // Beats dropped by a reset still leave the datapath for DP_LAT cycles;
  // keep the consistency check blind while they drain.
  always_ff @(posedge clk) begin
    if (rst)                 mask_cnt <= MW'(DP_LAT);
    else if (mask_cnt != '0) mask_cnt <= mask_cnt - MW'(1);
  end

  // Sticky flag for a datapath valid that disagrees with the tag pipe.
  always_ff @(posedge clk) begin
    if (rst)                                             err <= 1'b0;
    else if ((mask_cnt == '0) && (dp_vld_out != tag_vld)) err <= 1'b1;
  end

endmodule

// File: tb/tb_bn_share_sched.sv
// Bench for bn_share_sched: a small datapath emulator closes the loop. A
// cycle-indexed reference model predicts grants, issue registers, responses
// and err from the arbitration and latency rules.
module tb_bn_share_sched;
  localparam int NO_REQ = 4, NO_CH = 10, BW_IN = 12, BW_OUT = 12;
  localparam int BW_A = 12, BW_B = 12, DP_LAT = 4;
  localparam int DW = NO_CH*BW_IN, AW = NO_CH*BW_A, BBW = NO_CH*BW_B, OW = NO_CH*BW_OUT;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NO_REQ-1:0]        req;
  logic [NO_REQ*DW-1:0]     req_data;
  logic [NO_REQ-1:0]        gnt;
  logic                     cfg_we;
  logic [1:0]               cfg_sel;
  logic [3:0]               cfg_ch;
  logic [BW_A-1:0]          cfg_a;
  logic [BW_B-1:0]          cfg_b;
  logic                     dp_vld_in;
  logic [DW-1:0]            dp_data_in;
  logic [AW-1:0]            dp_a;
  logic [BBW-1:0]           dp_b;
  logic                     dp_vld_out;
  logic [OW-1:0]            dp_data_out;
  logic [NO_REQ-1:0]        rsp_vld;
  logic [OW-1:0]            rsp_data;
  logic                     err;
  logic                     force_vo;

  always #5 clk = ~clk;

  bn_share_sched #(.NO_REQ(NO_REQ), .NO_CH(NO_CH), .BW_IN(BW_IN), .BW_OUT(BW_OUT),
                   .BW_A(BW_A), .BW_B(BW_B), .DP_LAT(DP_LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_ch(cfg_ch), .cfg_a(cfg_a), .cfg_b(cfg_b),
    .dp_vld_in(dp_vld_in), .dp_data_in(dp_data_in), .dp_a(dp_a), .dp_b(dp_b),
    .dp_vld_out(dp_vld_out), .dp_data_out(dp_data_out),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data), .err(err)
  );

  // relu(x*a + b) per channel, truncated to BW_OUT.
  function automatic logic [OW-1:0] bn_f(input logic [DW-1:0] x, input logic [AW-1:0] a,
                                         input logic [BBW-1:0] b);
    logic [OW-1:0] r;
    int xi, ai, bi, p;
    r = '0;
    for (int c = 0; c < NO_CH; c++) begin
      xi = $signed(x[c*BW_IN +: BW_IN]);
      ai = $signed(a[c*BW_A +: BW_A]);
      bi = $signed(b[c*BW_B +: BW_B]);
      p  = xi * ai + bi;
      if (p < 0) p = 0;
      r[c*BW_OUT +: BW_OUT] = BW_OUT'(p);
    end
    return r;
  endfunction

  // Datapath emulator: fixed DP_LAT-cycle pipe, never reset.
  logic [DP_LAT-1:0]         dpv = '0;
  logic [DP_LAT-1:0][OW-1:0] dpd = '0;
  always @(posedge clk) begin
    dpv <= {dpv[DP_LAT-2:0], dp_vld_in};
    dpd <= {dpd[DP_LAT-2:0], bn_f(dp_data_in, dp_a, dp_b)};
  end
  assign dp_vld_out  = dpv[DP_LAT-1] | force_vo;
  assign dp_data_out = dpd[DP_LAT-1];

  int nvec = 0, nmis = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model state.
  int                m_ptr, m_mask, cyc;
  logic [AW-1:0]     m_a [NO_REQ];
  logic [BBW-1:0]    m_b [NO_REQ];
  logic              iss_vld, exp_err;
  logic [DW-1:0]     iss_d;
  logic [AW-1:0]     iss_a;
  logic [BBW-1:0]    iss_b;
  logic [NO_REQ-1:0] s_vld [64];
  logic [OW-1:0]     s_dat [64];

  function automatic int pick(input int p, input logic [NO_REQ-1:0] r);
    for (int i = 0; i < NO_REQ; i++)
      if (r[(p + i) % NO_REQ]) return (p + i) % NO_REQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_mask = DP_LAT; exp_err = 1'b0;
    iss_vld = 1'b0; iss_d = '0; iss_a = '0; iss_b = '0;
    for (int i = 0; i < NO_REQ; i++) begin m_a[i] = '0; m_b[i] = '0; end
    for (int i = 0; i < 64; i++) begin s_vld[i] = '0; s_dat[i] = '0; end
  endtask

  // One clock: check everything at the falling edge, advance the model,
  // then cross the rising edge and drop the request that was accepted.
  task automatic step();
    int k, slot, s;
    logic [NO_REQ-1:0] eg;
    @(negedge clk);
    k  = (rst || cfg_we) ? -1 : pick(m_ptr, req);
    eg = (k >= 0) ? (NO_REQ'(1) << k) : '0;
    slot = cyc % 64;
    chk("gnt", gnt, eg);
    chk("dp_vld_in", dp_vld_in, iss_vld);
    chk("dp_data_in", dp_data_in, iss_d);
    chk("dp_a", dp_a, iss_a);
    chk("dp_b", dp_b, iss_b);
    chk("rsp_vld", rsp_vld, s_vld[slot]);
    if (s_vld[slot] != '0) chk("rsp_data", rsp_data, s_dat[slot]);
    chk("err", err, exp_err);
    if (rst) model_reset();
    else begin
      if (m_mask == 0 && (dp_vld_out != (s_vld[slot] != '0))) exp_err = 1'b1;
      if (m_mask > 0) m_mask--;
      s_vld[slot] = '0;
      iss_vld = (k >= 0);
      if (k >= 0) begin
        iss_d = req_data[k*DW +: DW];
        iss_a = m_a[k];
        iss_b = m_b[k];
        s = (cyc + DP_LAT + 1) % 64;
        s_vld[s] = eg;
        s_dat[s] = bn_f(iss_d, iss_a, iss_b);
        m_ptr = (k + 1) % NO_REQ;
      end
      if (cfg_we && int'(cfg_sel) < NO_REQ && int'(cfg_ch) < NO_CH) begin
        m_a[cfg_sel][int'(cfg_ch)*BW_A +: BW_A] = cfg_a;
        m_b[cfg_sel][int'(cfg_ch)*BW_B +: BW_B] = cfg_b;
      end
    end
    cyc++;
    @(posedge clk); #1;
    req = req & ~eg;
  endtask

  task automatic raise(input int k);
    req[k] = 1'b1;
    for (int c = 0; c < NO_CH; c++) req_data[k*DW + c*BW_IN +: BW_IN] = BW_IN'($urandom);
  endtask

  task automatic cfg(input int sel, input int ch, input int a, input int b);
    cfg_we = 1'b1; cfg_sel = 2'(sel); cfg_ch = 4'(ch); cfg_a = BW_A'(a); cfg_b = BW_B'(b);
  endtask

  // Let pending requests be granted and in-flight results emerge; bounded.
  task automatic drain();
    int n = 0;
    cfg_we = 1'b0;
    while (req != '0 && n < 50) begin step(); n++; end
    chk("drain_bound", req, '0);
    repeat (DP_LAT + 2) step();
  endtask

  initial begin
    rst = 1'b1; req = '0; req_data = '0; cfg_we = 1'b0; cfg_sel = '0; cfg_ch = '0;
    cfg_a = '0; cfg_b = '0; force_vo = 1'b0; cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    step();
    rst = 1'b0;

    // 1: single requester, latency and coefficient routing
    cfg(1, 0, 64, 0);
    step();
    cfg_we = 1'b0;
    raise(1);
    req_data[1*DW +: BW_IN] = 12'd10;
    #1 chk("t1_gnt", gnt, 4'b0010);
    step();
    chk("t1_dp_vld", dp_vld_in, 1'b1);
    chk("t1_dp_a0", dp_a[BW_A-1:0], 12'd64);
    repeat (DP_LAT) step();
    chk("t1_rsp", rsp_vld, 4'b0010);
    chk("t1_rsp_d0", rsp_data[BW_OUT-1:0], 12'd640);
    drain();

    // 2: all requesters continuously busy
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < NO_REQ; k++) if (!req[k]) raise(k);
      step();
    end
    drain();

    // 3: config write blocks a full request vector, pointer holds
    for (int k = 0; k < NO_REQ; k++) raise(k);
    cfg(0, 3, $urandom, $urandom);
    #1 chk("t3_blk", gnt, 4'b0000);
    step();
    cfg_we = 1'b0;
    #1 chk("t3_same", gnt, NO_REQ'(1) << m_ptr);
    drain();

    // 4: rewrite of a set after its beat has issued
    cfg(2, 0, 5, 0);
    step();
    cfg_we = 1'b0;
    raise(2);
    step();
    cfg(2, 0, 7, 0);
    chk("t4_old_a", dp_a[BW_A-1:0], 12'd5);
    step();
    cfg_we = 1'b0;
    raise(2);
    step();
    chk("t4_new_a", dp_a[BW_A-1:0], 12'd7);
    drain();

    // 5: stray datapath valid with an empty tag pipe
    force_vo = 1'b1;
    step();
    force_vo = 1'b0;
    step();
    chk("t5_err", err, 1'b1);
    repeat (3) step();
    chk("t5_sticky", err, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_clr", err, 1'b0);

    // 6: reset with beats in flight
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < NO_REQ; k++) if (!req[k]) raise(k);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < NO_REQ; k++) raise(k);
    #1 chk("t6_gnt0", gnt, 4'b0001);
    repeat (DP_LAT + 3) step();
    chk("t6_err", err, 1'b0);
    drain();

    // random traffic mixed with config writes, including invalid channels
    for (int i = 0; i < 500; i++) begin
      for (int k = 0; k < NO_REQ; k++) if (!req[k] && $urandom_range(0, 1) == 1) raise(k);
      if ($urandom_range(0, 5) == 0) cfg($urandom_range(0, 3), $urandom_range(0, 15), $urandom, $urandom);
      else cfg_we = 1'b0;
      step();
    end
    drain();
    chk("final_err", err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
